// File: rtl/bpsk_packet_tx.sv
// bpsk_packet_tx: byte FIFO feeding a packet framer and BPSK modulator.
// Bytes arrive on a valid/ready stream. Each group of PACKET_BYTES bytes is
// sent behind a PREAMBLE byte, LSB first. Each bit lasts BIT_CYCLES clocks.
// Each bit is modulated onto a square carrier as signed samples.
// Optional build macro BPSK_PACKET_TX_DIFF_ENCODE_EN selects differential BPSK:
// a 1 bit flips the phase and a 0 bit keeps it.
// Without the macro, bit 1 maps to + and bit 0 maps to -.
// Handshake: a byte transfers on any rising clk edge where in_valid and
// in_ready are both high. in_valid/in_data must stay stable until then.
// in_ready never depends on in_valid.
`timescale 1ns/1ps
module bpsk_packet_tx #(
    parameter int         DATA_WIDTH   = 8,
    parameter int         PACKET_BYTES = 2,
    parameter int         FIFO_DEPTH   = 16,
    parameter int         BIT_CYCLES   = 4,
    parameter int         CARRIER_HALF = 1,
    parameter logic [7:0] PREAMBLE     = 8'hA5,
    parameter int         AMPLITUDE    = 100,
    parameter int         GAP_CYCLES   = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [7:0]                      in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic signed [DATA_WIDTH-1:0]    sample_out,
    output logic                            sample_valid,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int HW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int BW = $clog2(PACKET_BYTES + 1);
    localparam logic signed [DATA_WIDTH-1:0] AMP_POS = DATA_WIDTH'(AMPLITUDE);
    localparam logic signed [DATA_WIDTH-1:0] AMP_NEG = DATA_WIDTH'(-AMPLITUDE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_PAYLOAD,
        ST_GAP
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] count_q, count_d;
    logic          push, pop;

    // Framer / modulator position. These registers describe the sample
    // currently on sample_out, so outputs are computed from the _d values.
    state_t          state_q, state_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic [2:0]      bit_q, bit_d;
    logic [BW-1:0]   bytes_q, bytes_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [HW-1:0]   car_cnt_q, car_cnt_d;
    logic            car_neg_q, car_neg_d;
    logic            pkt_start, sym_start, start_ok, sym_neg, active_d;
    logic signed [DATA_WIDTH-1:0] sample_q, sample_d;
    logic            valid_q;

    assign in_ready   = !rst && (count_q < LW'(FIFO_DEPTH));
    assign push       = in_valid && in_ready;
    assign fifo_level = count_q;
    assign busy       = (state_q != ST_IDLE);
    assign sample_out = sample_q;
    assign sample_valid = valid_q;
    assign start_ok   = (count_q >= LW'(PACKET_BYTES));

    // FIFO occupancy: a push and a pop in the same cycle leave it unchanged
    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + LW'(1);
        else if (pop && !push)
            count_d = count_q - LW'(1);
    end

    // FIFO data array (contents need no reset; pointers define validity)
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= in_data;
    end

    // FIFO pointers and level
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Framer next state: bit/cycle counters, byte loads, gap timing, carrier
    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        bit_d     = bit_q;
        bytes_d   = bytes_q;
        shreg_d   = shreg_q;
        gap_d     = gap_q;
        car_cnt_d = car_cnt_q;
        car_neg_d = car_neg_q;
        pop       = 1'b0;
        sym_start = 1'b0;
        pkt_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok)
                    pkt_start = 1'b1;
            end
            ST_PREAMBLE, ST_PAYLOAD: begin
                if (car_cnt_q == HW'(CARRIER_HALF - 1)) begin
                    car_cnt_d = '0;
                    car_neg_d = ~car_neg_q;
                end else begin
                    car_cnt_d = car_cnt_q + HW'(1);
                end
                if (cyc_q != CW'(BIT_CYCLES - 1)) begin
                    cyc_d = cyc_q + CW'(1);
                end else begin
                    cyc_d = '0;
                    if (bit_q != 3'd7) begin
                        bit_d     = bit_q + 3'd1;
                        shreg_d   = {1'b0, shreg_q[7:1]};
                        sym_start = 1'b1;
                    end else if (bytes_q < BW'(PACKET_BYTES)) begin
                        pop       = 1'b1;
                        shreg_d   = mem_q[rd_ptr_q];
                        bit_d     = '0;
                        bytes_d   = bytes_q + BW'(1);
                        state_d   = ST_PAYLOAD;
                        sym_start = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                        gap_d   = '0;
                    end
                end
            end
            ST_GAP: begin
                // A ready next packet starts straight from the last gap cycle
                // so back-to-back packets are separated by exactly GAP_CYCLES.
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    if (start_ok)
                        pkt_start = 1'b1;
                    else
                        state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (pkt_start) begin
            state_d   = ST_PREAMBLE;
            shreg_d   = PREAMBLE;
            bit_d     = '0;
            cyc_d     = '0;
            bytes_d   = '0;
            car_cnt_d = '0;
            car_neg_d = 1'b0;
        end
    end

`ifdef BPSK_PACKET_TX_DIFF_ENCODE_EN
    logic ph_neg_q, ph_neg_d;

    // Differential phase: the reference is + at packet start; a 1 bit flips it
    always_comb begin
        ph_neg_d = ph_neg_q;
        if (pkt_start)
            ph_neg_d = shreg_d[0];
        else if (sym_start)
            ph_neg_d = ph_neg_q ^ shreg_d[0];
    end

    // Phase-history register
    always_ff @(posedge clk) begin
        if (rst)
            ph_neg_q <= 1'b0;
        else
            ph_neg_q <= ph_neg_d;
    end

    assign sym_neg = ph_neg_d;
`else
    assign sym_neg = ~shreg_d[0];
`endif

    assign active_d = (state_d == ST_PREAMBLE) || (state_d == ST_PAYLOAD);

    // Sample mapping: symbol phase times carrier sign, zero when not sending
    always_comb begin
        sample_d = '0;
        if (active_d)
            sample_d = (sym_neg ^ car_neg_d) ? AMP_NEG : AMP_POS;
    end

    // Framer state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cyc_q     <= '0;
            bit_q     <= '0;
            bytes_q   <= '0;
            shreg_q   <= '0;
            gap_q     <= '0;
            car_cnt_q <= '0;
            car_neg_q <= 1'b0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            bit_q     <= bit_d;
            bytes_q   <= bytes_d;
            shreg_q   <= shreg_d;
            gap_q     <= gap_d;
            car_cnt_q <= car_cnt_d;
            car_neg_q <= car_neg_d;
            sample_q  <= sample_d;
            valid_q   <= active_d;
        end
    end

endmodule

// File: tb/tb_bpsk_packet_tx.sv
// Self-checking bench for bpsk_packet_tx (default parameters plus a second
// instance with PACKET_BYTES=1, BIT_CYCLES=8, CARRIER_HALF=2).
// Expected samples come from a small bit-to-sample model. Expected bit streams
// and the fixed patterns are written out by hand.
`timescale 1ns/1ps
module tb_bpsk_packet_tx;
    localparam logic [7:0] P = 8'd100;   // +100
    localparam logic [7:0] N = 8'h9C;    // -100

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [23:0] exp_bits;   // {b1, b0, preamble}, sent LSB first
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] sample_out;
    logic       sample_valid, busy;
    logic [4:0] fifo_level;

    logic [7:0] in_data5 = '0;
    logic       in_valid5 = 1'b0;
    logic       in_ready5;
    logic [7:0] sample_out5;
    logic       sample_valid5, busy5;
    logic [4:0] fifo_level5;

    bpsk_packet_tx u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sample_out(sample_out), .sample_valid(sample_valid),
        .busy(busy), .fifo_level(fifo_level)
    );

    bpsk_packet_tx #(.PACKET_BYTES(1), .BIT_CYCLES(8), .CARRIER_HALF(2)) u_dut5 (
        .clk(clk), .rst(rst), .in_data(in_data5), .in_valid(in_valid5),
        .in_ready(in_ready5), .sample_out(sample_out5), .sample_valid(sample_valid5),
        .busy(busy5), .fifo_level(fifo_level5)
    );

    // ---------------- scoreboard state ----------------
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    logic       mon_en = 1'b0;
    logic       abort_mode = 1'b0;
    logic       gap_check = 1'b0;
    logic       in_pkt = 1'b0;
    logic       seen_end = 1'b0;
    int         pkt_len = 0;
    int         pkt_bad = 0;
    int         gap_len = 0;
    int         pkt_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Expected samples for one default-parameter frame (4 cycles/bit, half=1)
    task automatic exp_frame(input logic [23:0] bits);
        logic neg;
        logic cn;
`ifdef BPSK_PACKET_TX_DIFF_ENCODE_EN
        logic ph;
        ph = 1'b0;
`endif
        for (int i = 0; i < 24; i++) begin
`ifdef BPSK_PACKET_TX_DIFF_ENCODE_EN
            ph  = ph ^ bits[i];
            neg = ph;
`else
            neg = ~bits[i];
`endif
            for (int c = 0; c < 4; c++) begin
                cn = (c % 2) != 0;
                exp_q.push_back((cn ^ neg) ? N : P);
            end
        end
    endtask

    // Monitor: compares every valid sample against exp_q, checks packet
    // length and (optionally) the invalid gap between consecutive packets.
    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(posedge clk); #1;
            if (mon_en) begin
                if (sample_valid) begin
                    if (!in_pkt) begin
                        in_pkt  = 1'b1;
                        pkt_len = 0;
                        pkt_bad = 0;
                        if (gap_check && seen_end)
                            check("gap_invalid_cycles", gap_len, 8);
                    end
                    pkt_len++;
                    if (!abort_mode) begin
                        if (exp_q.size() == 0) begin
                            pkt_bad++;
                        end else begin
                            e = exp_q.pop_front();
                            if (sample_out !== e)
                                pkt_bad++;
                        end
                    end
                end else begin
                    if (in_pkt) begin
                        in_pkt   = 1'b0;
                        pkt_done++;
                        seen_end = 1'b1;
                        gap_len  = 1;
                        if (!abort_mode) begin
                            check("packet_length", pkt_len, 96);
                            check("packet_sample_errors", pkt_bad, 0);
                        end
                    end else begin
                        gap_len++;
                    end
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push(input logic [7:0] b);
        int t;
        t = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        check("push_accepted", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_start(input int limit);
        int t;
        t = 0;
        while (!sample_valid && t < limit) begin
            @(posedge clk); #1;
            t++;
        end
        check("packet_started", sample_valid, 1);
    endtask

    task automatic wait_idle(input int limit);
        int t;
        t = 0;
        while ((busy || sample_valid) && t < limit) begin
            @(posedge clk); #1;
            t++;
        end
        check("returned_idle", busy || sample_valid, 0);
        #1;
    endtask

    // Watchdog
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at 2 ms, required to finish earlier");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    vec_t       vecs[4];
    logic [7:0] pat[8];
    logic [7:0] got5[128];
    logic [7:0] sbytes[40];

    initial begin
        int done0, t, cnt, max_lvl, ready_bad, stalls, bad5;
        logic [15:0] bits5;
        logic neg5, cn5;
`ifdef BPSK_PACKET_TX_DIFF_ENCODE_EN
        logic ph5;
`endif

        vecs[0] = '{8'h80, 8'h01, 24'h0180A5};
        vecs[1] = '{8'h55, 8'hAA, 24'hAA55A5};
        vecs[2] = '{8'hF0, 8'h0F, 24'h0FF0A5};
        vecs[3] = '{8'h01, 8'h80, 24'h8001A5};

        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready_low", in_ready, 0);
        check("rst_sample_out", sample_out, 0);
        check("rst_sample_valid", sample_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_fifo_level", fifo_level, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        mon_en = 1'b1;

        // Test 1: 0xFF, 0x00
        done0 = pkt_done;
        exp_frame({8'h00, 8'hFF, 8'hA5});
        push(8'hFF);
        push(8'h00);
        check("t1_level_two", fifo_level, 2);
        check("t1_not_yet_valid", sample_valid, 0);
        @(posedge clk); #1;
        check("t1_valid_next_cycle", sample_valid, 1);
        check("t1_busy", busy, 1);
`ifdef BPSK_PACKET_TX_DIFF_ENCODE_EN
        check("t1_first_sample", sample_out, N);
`else
        check("t1_first_sample", sample_out, P);
`endif
        t = 0;
        while (sample_valid && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("t1_valid_dropped", sample_valid, 0);
        cnt = 0;
        t = 0;
        while (busy && t < 20) begin
            if (sample_valid) cnt++;
            @(posedge clk); #1;
            t++;
        end
        check("t1_gap_busy_cycles", t, 8);
        check("t1_gap_no_valid", cnt, 0);
        #1;
        check("t1_one_packet", pkt_done - done0, 1);

        // Test 2: a lone byte does not start a packet
        push(8'h3C);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (sample_valid) cnt++;
        end
        check("t2_no_valid_one_byte", cnt, 0);
        check("t2_level_one", fifo_level, 1);
        check("t2_idle", busy, 0);
        done0 = pkt_done;
        exp_frame({8'h11, 8'h3C, 8'hA5});
        push(8'h11);
        @(posedge clk); #1;
        check("t2_start_next_cycle", sample_valid, 1);
        wait_idle(300);
        check("t2_one_packet", pkt_done - done0, 1);

        // Table-driven packets
        for (int v = 0; v < 4; v++) begin
            done0 = pkt_done;
            exp_frame(vecs[v].exp_bits);
            push(vecs[v].b0);
            push(vecs[v].b1);
            wait_start(10);
            wait_idle(300);
            check("vec_one_packet", pkt_done - done0, 1);
            check("vec_fifo_empty", fifo_level, 0);
        end

        // Test 3: 40 bytes streamed back to back
        done0     = pkt_done;
        seen_end  = 1'b0;
        gap_check = 1'b1;
        max_lvl   = 0;
        ready_bad = 0;
        stalls    = 0;
        for (int i = 0; i < 40; i++)
            sbytes[i] = 8'(i * 13 + 5);
        for (int i = 0; i < 40; i += 2)
            exp_frame({sbytes[i+1], sbytes[i], 8'hA5});
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_data = sbytes[i];
            t = 0;
            while (!in_ready && t < 2000) begin
                if (32'(fifo_level) > max_lvl) max_lvl = 32'(fifo_level);
                @(posedge clk); #1;
                t++;
            end
            if (t >= 2000) stalls++;
            if (32'(fifo_level) > max_lvl) max_lvl = 32'(fifo_level);
            if (fifo_level == 5'd16 && in_ready) ready_bad++;
            @(posedge clk); #1;
            if (fifo_level == 5'd16 && in_ready) ready_bad++;
        end
        in_valid = 1'b0;
        check("t3_push_stalls", stalls, 0);
        check("t3_max_level", max_lvl, 16);
        check("t3_ready_low_when_full", ready_bad, 0);
        wait_idle(3000);
        check("t3_twenty_packets", pkt_done - done0, 20);
        check("t3_all_expected_used", exp_q.size(), 0);
        gap_check = 1'b0;

        // Test 4: reset at valid sample 40
        abort_mode = 1'b1;
        push(8'h12);
        push(8'h34);
        push(8'h56);
        push(8'h78);
        t = 0;
        @(posedge clk); #2;
        while (!(in_pkt && pkt_len >= 40) && t < 200) begin
            @(posedge clk); #2;
            t++;
        end
        check("t4_reached_sample_40", pkt_len, 40);
        rst = 1'b1;
        #1;
        check("t4_in_ready_low_in_rst", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("t4_sample_out_zero", sample_out, 0);
        check("t4_sample_valid_zero", sample_valid, 0);
        check("t4_fifo_flushed", fifo_level, 0);
        check("t4_busy_zero", busy, 0);
        #1;
        abort_mode = 1'b0;
        check("t4_in_ready_after_rst", in_ready, 1);
        repeat (5) @(posedge clk);
        #1;
        check("t4_no_resume", sample_valid, 0);
        done0 = pkt_done;
        exp_frame({8'hBC, 8'h9A, 8'hA5});
        push(8'h9A);
        push(8'hBC);
        wait_start(10);
        wait_idle(300);
        check("t4_fresh_packet", pkt_done - done0, 1);

        // Test 5: PACKET_BYTES=1, BIT_CYCLES=8, CARRIER_HALF=2
        check("t5_ready", in_ready5, 1);
        in_data5  = 8'hFF;
        in_valid5 = 1'b1;
        @(posedge clk); #1;
        in_valid5 = 1'b0;
        t = 0;
        while (!sample_valid5 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check("t5_started", sample_valid5, 1);
        cnt = 0;
        while (sample_valid5 && cnt < 300) begin
            if (cnt < 128) got5[cnt] = sample_out5;
            cnt++;
            @(posedge clk); #1;
        end
        check("t5_packet_length", cnt, 128);
        bits5 = {8'hFF, 8'hA5};
        bad5 = 0;
`ifdef BPSK_PACKET_TX_DIFF_ENCODE_EN
        ph5 = 1'b0;
`endif
        for (int i = 0; i < 16; i++) begin
`ifdef BPSK_PACKET_TX_DIFF_ENCODE_EN
            ph5  = ph5 ^ bits5[i];
            neg5 = ph5;
`else
            neg5 = ~bits5[i];
`endif
            for (int c = 0; c < 8; c++) begin
                cn5 = ((c / 2) % 2) != 0;
                if (got5[i*8 + c] !== ((cn5 ^ neg5) ? N : P)) bad5++;
            end
        end
        check("t5_sample_errors", bad5, 0);
`ifdef BPSK_PACKET_TX_DIFF_ENCODE_EN
        pat = '{N, N, P, P, N, N, P, P};
`else
        pat = '{P, P, N, N, P, P, N, N};
`endif
        for (int k = 0; k < 8; k++)
            check("t5_first_payload_bit", got5[64 + k], pat[k]);
        t = 0;
        while (busy5 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("t5_idle_after_gap", busy5, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
